ls74194: RTL and testbench

- 4-bit bidirectional universal shift register, modelled on the 74LS194.
- Sits directly upstream of the ls7486 quad XOR as its operand register: q drives the XOR `a` (or `b`) input.
- Supports hold, shift-right, shift-left and parallel load, so operands can be staged, rotated or serially assembled before the XOR stage.
- WIDTH is parameterised so two instances can cascade into an 8-bit operand path.

---
 rtl/ls74194_if.sv | 33 +++
 rtl/ls74194.sv | 51 +++++
 tb/tb_ls74194.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ls74194_if.sv
// ----------------------------------------------------------------------------
// ls74194_if
// Operand-register bus for the ls74194 universal shift register.
//   s      [1:0]      mode select (s[1]=S1, s[0]=S0)
//   dsr               serial in for shift-right (enters at q[0])
//   dsl               serial in for shift-left (enters at q[WIDTH-1])
//   d      [WIDTH-1:0] parallel load data
//   q      [WIDTH-1:0] register contents
//   ser_r             cascade out for right shift (q[WIDTH-1])
//   ser_l             cascade out for left shift (q[0])
// master: the controller driving mode/data; slave: the register itself.
// ----------------------------------------------------------------------------
interface ls74194_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       s;
    logic             dsr;
    logic             dsl;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             ser_r;
    logic             ser_l;

    modport master (
        output s, dsr, dsl, d,
        input  q, ser_r, ser_l
    );

    modport slave (
        input  s, dsr, dsl, d,
        output q, ser_r, ser_l
    );
endinterface

// File: rtl/ls74194.sv
// ----------------------------------------------------------------------------
// ls74194
// WIDTH-bit bidirectional universal shift register modelled on the 74LS194.
// Stages operands for the downstream ls7486 XOR.
//   clk    rising-edge clock
//   clr_n  asynchronous active-low clear (q forced to zero)
//   bus    ls74194_if.slave: s, dsr, dsl, d in; q, ser_r, ser_l out
// Modes: 00 hold, 01 shift right (toward q[WIDTH-1]), 10 shift left
// (toward q[0]), 11 parallel load. Serial outputs are taps of the register,
// so tying dsr to ser_r (or dsl to ser_l) rotates without a comb loop.
// The bus interface WIDTH must match this module's WIDTH.
// ----------------------------------------------------------------------------
module ls74194 #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      clr_n,
    ls74194_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_r;
    mode_e            mode;

    assign mode = mode_e'(bus.s);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r <= '0;
        end else begin
            unique case (mode)
                MODE_HOLD: q_r <= q_r;
                MODE_SHR:  q_r <= {q_r[WIDTH-2:0], bus.dsr};
                MODE_SHL:  q_r <= {bus.dsl, q_r[WIDTH-1:1]};
                MODE_LOAD: q_r <= bus.d;
                default:   q_r <= q_r;
            endcase
        end
    end

    assign bus.q     = q_r;
    assign bus.ser_r = q_r[WIDTH-1];
    assign bus.ser_l = q_r[0];

endmodule

// File: tb/tb_ls74194.sv
// ----------------------------------------------------------------------------
// tb_ls74194
// Directed-vector scoreboard bench for ls74194. Stimulus pushes the expected
// register value into a queue and fires sample_ev; a separate monitor pops
// each entry and compares it with the selected DUT's outputs.
// Instances: u0 (single register), u_lo/u_hi (cascaded for right shift).
// ----------------------------------------------------------------------------
module tb_ls74194;

    localparam int W = 4;

    // which: 0 = u0, 1 = u_lo, 2 = u_hi, 3 = XOR of u0.q with b=0101
    typedef struct {
        string       name;
        int unsigned which;
        logic [W-1:0] exp;
    } sb_item_t;

    logic clk;
    logic clr_n;

    ls74194_if #(.WIDTH(W)) bus0 ();
    ls74194_if #(.WIDTH(W)) bus_lo ();
    ls74194_if #(.WIDTH(W)) bus_hi ();

    ls74194 #(.WIDTH(W)) u0   (.clk(clk), .clr_n(clr_n), .bus(bus0));
    ls74194 #(.WIDTH(W)) u_lo (.clk(clk), .clr_n(clr_n), .bus(bus_lo));
    ls74194 #(.WIDTH(W)) u_hi (.clk(clk), .clr_n(clr_n), .bus(bus_hi));

    sb_item_t sb[$];
    event     sample_ev;
    int       total;
    int       bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: drains the scoreboard whenever stimulus signals a sample.
    // ------------------------------------------------------------------
    initial begin
        sb_item_t     it;
        logic [W-1:0] act_q;
        logic         act_r;
        logic         act_l;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                total++;
                case (it.which)
                    0: begin act_q = bus0.q;   act_r = bus0.ser_r;   act_l = bus0.ser_l;   end
                    1: begin act_q = bus_lo.q; act_r = bus_lo.ser_r; act_l = bus_lo.ser_l; end
                    2: begin act_q = bus_hi.q; act_r = bus_hi.ser_r; act_l = bus_hi.ser_l; end
                    default: begin
                        act_q = bus0.q ^ 4'b0101;
                        act_r = it.exp[W-1];
                        act_l = it.exp[0];
                    end
                endcase
                if (act_q !== it.exp || act_r !== it.exp[W-1] || act_l !== it.exp[0]) begin
                    bad++;
                    $display("FAIL %s: got q=%b ser_r=%b ser_l=%b, want q=%b ser_r=%b ser_l=%b",
                             it.name, act_q, act_r, act_l, it.exp, it.exp[W-1], it.exp[0]);
                end
            end
        end
    end

    task automatic expect_q(input string nm, input int unsigned which, input logic [W-1:0] e);
        sb_item_t it;
        it.name  = nm;
        it.which = which;
        it.exp   = e;
        sb.push_back(it);
        -> sample_ev;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [3:0] dsr_seq;
    logic [3:0] dsl_seq;
    logic [3:0] sr_exp [4];
    logic [3:0] sl_exp [4];

    initial begin
        total = 0;
        bad   = 0;
        dsr_seq = 4'b1101;   // applied LSB first: 1,0,1,1
        dsl_seq = 4'b1011;   // applied LSB first: 1,1,0,1
        sr_exp = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        sl_exp = '{4'b1000, 4'b1100, 4'b0110, 4'b1011};

        clr_n = 1'b0;
        bus0.s = 2'b00;   bus0.d = '0;   bus0.dsr = 1'b0;   bus0.dsl = 1'b0;
        bus_lo.s = 2'b00; bus_lo.d = '0; bus_lo.dsr = 1'b0; bus_lo.dsl = 1'b0;
        bus_hi.s = 2'b00; bus_hi.d = '0; bus_hi.dsr = 1'b0; bus_hi.dsl = 1'b0;

        #2;
        expect_q("reset_u0", 0, 4'b0000);
        expect_q("reset_lo", 1, 4'b0000);
        expect_q("reset_hi", 2, 4'b0000);

        // Async clear
        step();
        clr_n  = 1'b1;
        bus0.s = 2'b11;
        bus0.d = 4'b1010;
        step();
        expect_q("preclear_load", 0, 4'b1010);
        #2;                     // mid-cycle, no clock edge
        clr_n = 1'b0;
        #1;
        expect_q("async_clear", 0, 4'b0000);
        bus0.s = 2'b11;
        bus0.d = 4'b1111;
        step();
        expect_q("clear_hold_e1", 0, 4'b0000);
        step();
        expect_q("clear_hold_e2", 0, 4'b0000);

        // Parallel load and hold
        clr_n  = 1'b1;
        bus0.d = 4'b1010;
        step();
        expect_q("load_1010", 0, 4'b1010);
        bus0.s = 2'b00;
        bus0.d = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_q($sformatf("hold_e%0d", i + 1), 0, 4'b1010);
        end

        // Shift right from zero
        bus0.s = 2'b11;
        bus0.d = 4'b0000;
        step();
        expect_q("load_zero_sr", 0, 4'b0000);
        bus0.s = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus0.dsr = dsr_seq[i];
            step();
            expect_q($sformatf("shr_e%0d", i + 1), 0, sr_exp[i]);
        end

        // Shift left from zero
        bus0.s = 2'b11;
        bus0.d = 4'b0000;
        step();
        expect_q("load_zero_sl", 0, 4'b0000);
        bus0.s = 2'b10;
        for (int i = 0; i < 4; i++) begin
            bus0.dsl = dsl_seq[i];
            step();
            expect_q($sformatf("shl_e%0d", i + 1), 0, sl_exp[i]);
        end

        // Rotate right feeding the XOR stage (b = 0101)
        bus0.s = 2'b11;
        bus0.d = 4'b0101;
        step();
        expect_q("rot_load", 0, 4'b0101);
        bus0.s   = 2'b01;
        bus0.dsr = bus0.ser_r;
        step();
        expect_q("rot_e1", 0, 4'b1010);
        expect_q("xor_y_e1", 3, 4'b1111);
        bus0.dsr = bus0.ser_r;
        step();
        expect_q("rot_e2", 0, 4'b0101);
        expect_q("xor_y_e2", 3, 4'b0000);

        // Cascade: high:low = 0000_1111
        bus0.s   = 2'b00;
        bus_lo.s = 2'b11; bus_lo.d = 4'b1111;
        bus_hi.s = 2'b11; bus_hi.d = 4'b0000;
        step();
        expect_q("casc_load_lo", 1, 4'b1111);
        expect_q("casc_load_hi", 2, 4'b0000);
        bus_lo.s = 2'b01; bus_lo.dsr = 1'b0;
        bus_hi.s = 2'b01; bus_hi.dsr = bus_lo.ser_r;
        step();
        expect_q("casc_shr_lo", 1, 4'b1110);
        expect_q("casc_shr_hi", 2, 4'b0001);
        bus_lo.s = 2'b11; bus_lo.d = 4'b0110;
        bus_hi.s = 2'b11; bus_hi.d = 4'b0110;
        bus_hi.dsr = bus_lo.ser_r;
        step();
        expect_q("casc_ld_lo", 1, 4'b0110);
        expect_q("casc_ld_hi", 2, 4'b0110);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
